// File: rtl/tt_ctrl_pkg.sv
// Shared types and constants for the TinyTapeout control selector.
// The TT_CTRL_DEBOUNCE_EN build option is handled in tt_ctrl_sync_in.
package tt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_GUARD = 2'd1,
        ST_RUN   = 2'd2
    } tt_sel_state_t;

    // Synchroniser reset values: the block leaves reset in HOLD with enable off.
    localparam logic RST_N_SYNC_RST = 1'b0;
    localparam logic INC_SYNC_RST   = 1'b0;
    localparam logic ENA_SYNC_RST   = 1'b0;

endpackage

// File: rtl/tt_ctrl_sync_in.sv
// Pad input conditioner: SYNC_STAGES-deep synchroniser, plus a debounce
// filter when TT_CTRL_DEBOUNCE_EN is defined.
module tt_ctrl_sync_in #(
    parameter int   SYNC_STAGES = 2,
    parameter int   DEB_CYC     = 8,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

`ifdef TT_CTRL_DEBOUNCE_EN
    localparam int DCNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEB_CYC - 1);

    logic              filt_q;
    logic [DCNT_W-1:0] dcnt;

    // Output flips only after DEB_CYC consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= RST_VAL;
            dcnt   <= '0;
        end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
            dcnt <= '0;
        end else if (dcnt == DCNT_LAST) begin
            filt_q <= sync_q[SYNC_STAGES-1];
            dcnt   <= '0;
        end else begin
            dcnt <= dcnt + DCNT_W'(1);
        end
    end

    assign dout = filt_q;
`else
    logic unused_deb_cfg;
    assign unused_deb_cfg = (DEB_CYC > 0);
    assign dout = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/tt_ctrl_sel_seq.sv
// Synchronous design selector: registered address with wrap limit,
// break-before-make enable guard. Optional debounce via TT_CTRL_DEBOUNCE_EN.
module tt_ctrl_sel_seq
    import tt_ctrl_pkg::*;
#(
    parameter int SEL_W       = 10,
    parameter int N_DES       = 1024,
    parameter int GUARD       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYC     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ctrl_sel_rst_n,
    input  logic             ctrl_sel_inc,
    input  logic             ctrl_ena,
    output logic [SEL_W-1:0] sel_out,
    output logic             ena_out,
    output logic             sel_valid,
    output logic             sel_wrap
);

    localparam int GCNT_W = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [GCNT_W-1:0] GCNT_RELOAD = GCNT_W'(GUARD - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST    = SEL_W'(N_DES - 1);

    logic rst_n_s;
    logic inc_s;
    logic ena_s;
    logic inc_d;
    logic inc_pulse;

    tt_sel_state_t     state;
    logic [GCNT_W-1:0] gcnt;

    tt_ctrl_sync_in #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYC     (DEB_CYC),
        .RST_VAL     (RST_N_SYNC_RST)
    ) u_sync_rst_n (
        .clk  (clk),
        .rst  (rst),
        .din  (ctrl_sel_rst_n),
        .dout (rst_n_s)
    );

    tt_ctrl_sync_in #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYC     (DEB_CYC),
        .RST_VAL     (INC_SYNC_RST)
    ) u_sync_inc (
        .clk  (clk),
        .rst  (rst),
        .din  (ctrl_sel_inc),
        .dout (inc_s)
    );

    tt_ctrl_sync_in #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYC     (DEB_CYC),
        .RST_VAL     (ENA_SYNC_RST)
    ) u_sync_ena (
        .clk  (clk),
        .rst  (rst),
        .din  (ctrl_ena),
        .dout (ena_s)
    );

    assign inc_pulse = inc_s & ~inc_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            inc_d    <= 1'b0;
            state    <= ST_HOLD;
            gcnt     <= '0;
            sel_out  <= '0;
            sel_wrap <= 1'b0;
        end else begin
            inc_d    <= inc_s;
            sel_wrap <= 1'b0;
            if (!rst_n_s) begin
                state   <= ST_HOLD;
                gcnt    <= '0;
                sel_out <= '0;
            end else begin
                case (state)
                    ST_HOLD: begin
                        state <= ST_GUARD;
                        gcnt  <= GCNT_RELOAD;
                    end
                    ST_GUARD, ST_RUN: begin
                        if (inc_pulse) begin
                            // Any selection change re-arms the full guard window.
                            state <= ST_GUARD;
                            gcnt  <= GCNT_RELOAD;
                            if (sel_out == SEL_LAST) begin
                                sel_out  <= '0;
                                sel_wrap <= 1'b1;
                            end else begin
                                sel_out <= sel_out + SEL_W'(1);
                            end
                        end else if (state == ST_GUARD) begin
                            if (gcnt == '0) begin
                                state <= ST_RUN;
                            end else begin
                                gcnt <= gcnt - GCNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= ST_HOLD;
                        gcnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign sel_valid = (state == ST_RUN);
    assign ena_out   = sel_valid & ena_s;

endmodule

// File: tb/tb_tt_ctrl_sel_seq.sv
// Bench for tt_ctrl_sel_seq: a default-size instance and an N_DES=5 instance
// share the pads and are checked every cycle against a behavioural model.
module tb_tt_ctrl_sel_seq;

    localparam int SS  = 2;
    localparam int GRD = 4;
    localparam int DEB = 8;

    logic clk = 1'b0;
    logic rst;
    logic ctrl_sel_rst_n;
    logic ctrl_sel_inc;
    logic ctrl_ena;

    logic [9:0] sel_a;
    logic       ena_a, val_a, wrap_a;
    logic [2:0] sel_b;
    logic       ena_b, val_b, wrap_b;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    bit sync_m [3][SS];
    bit filt_m [3];
    int dcnt_m [3];
    bit inc_d_m;
    bit held_m;
    int off_left_m;   // enable-off cycles still to serve after a change
    int sel_m, sel5_m;
    bit wrap_m, wrap5_m;

    int wrap5_count;
    int ena_low_count;
    int sel_snap;
    int r;

    always #5 clk = ~clk;

    tt_ctrl_sel_seq #(
        .SEL_W (10), .N_DES (1024), .GUARD (GRD), .SYNC_STAGES (SS), .DEB_CYC (DEB)
    ) dut_a (
        .clk (clk), .rst (rst), .ctrl_sel_rst_n (ctrl_sel_rst_n),
        .ctrl_sel_inc (ctrl_sel_inc), .ctrl_ena (ctrl_ena),
        .sel_out (sel_a), .ena_out (ena_a), .sel_valid (val_a), .sel_wrap (wrap_a)
    );

    tt_ctrl_sel_seq #(
        .SEL_W (3), .N_DES (5), .GUARD (GRD), .SYNC_STAGES (SS), .DEB_CYC (DEB)
    ) dut_b (
        .clk (clk), .rst (rst), .ctrl_sel_rst_n (ctrl_sel_rst_n),
        .ctrl_sel_inc (ctrl_sel_inc), .ctrl_ena (ctrl_ena),
        .sel_out (sel_b), .ena_out (ena_b), .sel_valid (val_b), .sel_wrap (wrap_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond(input int i);
`ifdef TT_CTRL_DEBOUNCE_EN
        return filt_m[i];
`else
        return sync_m[i][SS-1];
`endif
    endfunction

    task automatic model_step();
        bit pads [3];
        bit c_rn, c_inc, pulse;
        pads[0] = ctrl_sel_rst_n;
        pads[1] = ctrl_sel_inc;
        pads[2] = ctrl_ena;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int k = 0; k < SS; k++) sync_m[i][k] = 1'b0;
                filt_m[i] = 1'b0;
                dcnt_m[i] = 0;
            end
            inc_d_m = 0; held_m = 1; off_left_m = 0;
            sel_m = 0; sel5_m = 0; wrap_m = 0; wrap5_m = 0;
            return;
        end
        c_rn  = cond(0);
        c_inc = cond(1);
        pulse = c_inc && !inc_d_m;
        wrap_m = 0;
        wrap5_m = 0;
        if (!c_rn) begin
            held_m = 1; off_left_m = 0; sel_m = 0; sel5_m = 0;
        end else if (held_m) begin
            held_m = 0; off_left_m = GRD;
        end else if (pulse) begin
            sel_m  = (sel_m + 1) % 1024;
            sel5_m = (sel5_m + 1) % 5;
            wrap_m  = (sel_m == 0);
            wrap5_m = (sel5_m == 0);
            off_left_m = GRD;
        end else if (off_left_m > 0) begin
            off_left_m--;
        end
        inc_d_m = c_inc;
        for (int i = 0; i < 3; i++) begin
            if (sync_m[i][SS-1] == filt_m[i]) dcnt_m[i] = 0;
            else if (++dcnt_m[i] == DEB) begin
                filt_m[i] = sync_m[i][SS-1];
                dcnt_m[i] = 0;
            end
            for (int k = SS - 1; k > 0; k--) sync_m[i][k] = sync_m[i][k-1];
            sync_m[i][0] = pads[i];
        end
    endtask

    task automatic tick(input int n);
        bit exp_valid;
        repeat (n) begin
            model_step();
            @(posedge clk);
            #1;
            exp_valid = !held_m && (off_left_m == 0);
            chk("sel_a",   32'(sel_a),  32'(sel_m));
            chk("valid_a", 32'(val_a),  32'(exp_valid));
            chk("ena_a",   32'(ena_a),  32'(exp_valid && cond(2)));
            chk("wrap_a",  32'(wrap_a), 32'(wrap_m));
            chk("sel_b",   32'(sel_b),  32'(sel5_m));
            chk("valid_b", 32'(val_b),  32'(exp_valid));
            chk("ena_b",   32'(ena_b),  32'(exp_valid && cond(2)));
            chk("wrap_b",  32'(wrap_b), 32'(wrap5_m));
            wrap5_count   += int'(wrap_b);
            ena_low_count += int'(!ena_a);
        end
    endtask

    initial begin
        rst = 1'b1; ctrl_sel_rst_n = 1'b0; ctrl_sel_inc = 1'b0; ctrl_ena = 1'b0;
        wrap5_count = 0; ena_low_count = 0;
        tick(3);
        chk("reset_sel",   32'(sel_a),  0);
        chk("reset_ena",   32'(ena_a),  0);
        chk("reset_valid", 32'(val_a),  0);
        chk("reset_wrap",  32'(wrap_a), 0);
        rst = 1'b0;
        tick(3);

        // Reset exit
        ctrl_sel_rst_n = 1'b1; ctrl_ena = 1'b1;
        tick(20);
        chk("exit_ena", 32'(ena_a), 1);
        chk("exit_sel", 32'(sel_a), 0);

`ifndef TT_CTRL_DEBOUNCE_EN
        // Increments and wrap on the N_DES=5 instance
        wrap5_count = 0;
        repeat (5) begin
            ctrl_sel_inc = 1'b1; tick(2);
            ctrl_sel_inc = 1'b0; tick(8);
        end
        chk("inc_sel_a",  32'(sel_a), 5);
        chk("wrap_sel_b", 32'(sel_b), 0);
        chk("wrap_count", 32'(wrap5_count), 1);
        chk("inc_ena",    32'(ena_a), 1);

        // Guard restart: second change two cycles into the guard
        ena_low_count = 0;
        ctrl_sel_inc = 1'b1; tick(1);
        ctrl_sel_inc = 1'b0; tick(1);
        ctrl_sel_inc = 1'b1; tick(1);
        ctrl_sel_inc = 1'b0; tick(10);
        chk("restart_sel", 32'(sel_a), 7);
        chk("restart_low", 32'(ena_low_count), 6);

        // Selection reset wins over a simultaneous increment
        ctrl_sel_rst_n = 1'b0; ctrl_sel_inc = 1'b1;
        tick(5);
        chk("prio_sel",   32'(sel_a), 0);
        chk("prio_valid", 32'(val_a), 0);
        chk("prio_ena",   32'(ena_a), 0);
        ctrl_sel_inc = 1'b0; ctrl_sel_rst_n = 1'b1;
        tick(10);
`else
        sel_snap = int'(sel_a);
        ctrl_sel_inc = 1'b1; tick(5);
        ctrl_sel_inc = 1'b0; tick(20);
        chk("glitch_sel", 32'(sel_a), 32'(sel_snap));
        ctrl_sel_inc = 1'b1; tick(12);
        ctrl_sel_inc = 1'b0; tick(30);
        chk("deb_sel", 32'(sel_a), 32'(sel_snap + 1));
`endif

        // Enable follows ctrl_ena during RUN
        ctrl_ena = 1'b0; tick(12);
        chk("ena_off", 32'(ena_a), 0);
        ctrl_ena = 1'b1; tick(12);
        chk("ena_on", 32'(ena_a), 1);

        // Randomized pad activity
        repeat (400) begin
            r = int'($urandom_range(0, 99));
            if (r < 50)      ctrl_sel_inc = ~ctrl_sel_inc;
            else if (r < 62) ctrl_ena = 1'($urandom);
            else if (r < 68) ctrl_sel_rst_n = ($urandom_range(0, 3) != 0);
            else if (r < 70) rst = 1'b1;
            tick(int'($urandom_range(2, 12)));
            rst = 1'b0;
        end

        // Block reset in the middle of a guard window
        ctrl_sel_rst_n = 1'b1; ctrl_ena = 1'b1; ctrl_sel_inc = 1'b0;
        tick(40);
        ctrl_sel_inc = 1'b1; tick(SS + 2);
        rst = 1'b1; tick(1);
        chk("midrst_sel",   32'(sel_a),  0);
        chk("midrst_ena",   32'(ena_a),  0);
        chk("midrst_valid", 32'(val_a),  0);
        chk("midrst_wrap",  32'(wrap_b), 0);
        rst = 1'b0; ctrl_sel_inc = 1'b0;
        tick(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
